// File: rtl/op_decode_seq.sv
// Registered decode stage for the accumulator ISA with load-wait sequencing, flush and retire count.
// Optional feature: define ILLEGAL_OP_TRAP_EN to trap (sticky until Reset) on opcodes >= 11.
module op_decode_seq #(
  parameter int IW      = 9,
  parameter int OPW     = 4,
  parameter int FW      = IW - OPW,
  parameter int LD_WAIT = 1,
  parameter int CNTW    = 16
) (
  input  logic            CLK,
  input  logic            Reset,
  input  logic            inst_valid,
  input  logic [IW-1:0]   inst,
  output logic            inst_ready,
  input  logic            flush,
  input  logic            out_ready,
  output logic            out_valid,
  output logic [OPW-1:0]  out_op,
  output logic [FW-1:0]   out_field,
  output logic            out_mode,
  output logic            reg_write,
  output logic            mem_read,
  output logic            mem_write,
  output logic            branch,
  output logic            acc_write,
  output logic            imm_sel,
  output logic            trap,
  output logic [CNTW-1:0] retired
);

  localparam logic [OPW-1:0] OP_ADD = OPW'(0);
  localparam logic [OPW-1:0] OP_LDS = OPW'(1);
  localparam logic [OPW-1:0] OP_XOR = OPW'(2);
  localparam logic [OPW-1:0] OP_BRC = OPW'(3);
  localparam logic [OPW-1:0] OP_GST = OPW'(4);
  localparam logic [OPW-1:0] OP_LSB = OPW'(5);
  localparam logic [OPW-1:0] OP_MSB = OPW'(6);
  localparam logic [OPW-1:0] OP_LRS = OPW'(7);
  localparam logic [OPW-1:0] OP_ACC = OPW'(8);
  localparam logic [OPW-1:0] OP_ENQ = OPW'(9);
  localparam logic [OPW-1:0] OP_EQI = OPW'(10);
  localparam logic [1:0]     WAIT_LOAD = 2'(LD_WAIT);

`ifdef ILLEGAL_OP_TRAP_EN
  typedef enum logic [1:0] {EMPTY, WAIT, FULL, TRAP} stateT;
`else
  typedef enum logic [1:0] {EMPTY, WAIT, FULL} stateT;
`endif

  stateT       state;
  logic [1:0]  waitCnt;
  logic [OPW-1:0] opc;
  logic        modeBit;
  logic        isLoad;
  logic        accept;
  logic        flushEff;
  logic        dRegWrite, dMemRead, dMemWrite, dBranch, dAccWrite, dImmSel;

  assign opc     = inst[IW-1 -: OPW];
  assign modeBit = inst[FW-1];
  assign isLoad  = (opc == OP_LDS) && !modeBit;

  assign inst_ready = !Reset && !flush &&
                      ((state == EMPTY) || ((state == FULL) && out_ready));
  assign accept     = inst_valid && inst_ready;

`ifdef ILLEGAL_OP_TRAP_EN
  logic isIllegal;
  logic trapR;
  assign isIllegal = (opc > OP_EQI);
  assign flushEff  = flush && (state != TRAP);
  assign trap      = trapR;
`else
  assign flushEff  = flush;
  assign trap      = 1'b0;
`endif

  always_comb begin
    dRegWrite = 1'b0;
    dMemRead  = 1'b0;
    dMemWrite = 1'b0;
    dBranch   = 1'b0;
    dAccWrite = 1'b0;
    dImmSel   = 1'b0;
    case (opc)
      OP_ADD, OP_XOR, OP_LSB, OP_MSB, OP_LRS, OP_ENQ: dRegWrite = 1'b1;
      OP_EQI: begin
        dRegWrite = 1'b1;
        dImmSel   = 1'b1;
      end
      OP_LDS: begin
        dRegWrite = !modeBit;
        dMemRead  = !modeBit;
        dMemWrite = modeBit;
      end
      OP_BRC: dBranch = 1'b1;
      OP_GST: begin
        dRegWrite = !modeBit;
        dAccWrite = modeBit;
      end
      OP_ACC: begin
        dAccWrite = 1'b1;
        dImmSel   = 1'b1;
      end
      default: ;
    endcase
  end

  // Retire counting is independent of flush: a word taken downstream in a flush cycle still counts.
  always_ff @(posedge CLK) begin
    if (Reset) begin
      state     <= EMPTY;
      waitCnt   <= '0;
      out_valid <= 1'b0;
      out_op    <= '0;
      out_field <= '0;
      out_mode  <= 1'b0;
      reg_write <= 1'b0;
      mem_read  <= 1'b0;
      mem_write <= 1'b0;
      branch    <= 1'b0;
      acc_write <= 1'b0;
      imm_sel   <= 1'b0;
      retired   <= '0;
`ifdef ILLEGAL_OP_TRAP_EN
      trapR     <= 1'b0;
`endif
    end else begin
      if (out_valid && out_ready)
        retired <= retired + CNTW'(1);

      if (flushEff) begin
        state     <= EMPTY;
        out_valid <= 1'b0;
        waitCnt   <= '0;
      end else if (accept) begin
`ifdef ILLEGAL_OP_TRAP_EN
        if (isIllegal) begin
          state     <= TRAP;
          out_valid <= 1'b0;
          trapR     <= 1'b1;
        end else begin
`else
        begin
`endif
          out_op    <= opc;
          out_field <= inst[FW-1:0];
          out_mode  <= modeBit;
          reg_write <= dRegWrite;
          mem_read  <= dMemRead;
          mem_write <= dMemWrite;
          branch    <= dBranch;
          acc_write <= dAccWrite;
          imm_sel   <= dImmSel;
          if (isLoad && (LD_WAIT > 0)) begin
            state     <= WAIT;
            out_valid <= 1'b0;
            waitCnt   <= WAIT_LOAD;
          end else begin
            state     <= FULL;
            out_valid <= 1'b1;
          end
        end
      end else begin
        case (state)
          WAIT: begin
            waitCnt <= waitCnt - 2'd1;
            if (waitCnt <= 2'd1) begin
              state     <= FULL;
              out_valid <= 1'b1;
            end
          end
          FULL: begin
            if (out_ready) begin
              state     <= EMPTY;
              out_valid <= 1'b0;
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_op_decode_seq.sv
// Self-checking bench for op_decode_seq: directed scenarios plus random traffic against a
// transaction-level reference model (word held + remaining delay); honours ILLEGAL_OP_TRAP_EN.
module tb_op_decode_seq;

  localparam int IW   = 9;
  localparam int OPW  = 4;
  localparam int FW   = IW - OPW;
  localparam int LDW  = 2;
  localparam int CNTW = 16;

  logic            CLK = 1'b0;
  logic            Reset = 1'b1;
  logic            inst_valid = 1'b0;
  logic [IW-1:0]   inst = '0;
  logic            flush = 1'b0;
  logic            out_ready = 1'b0;
  logic            inst_ready, out_valid, out_mode, trap;
  logic [OPW-1:0]  out_op;
  logic [FW-1:0]   out_field;
  logic            reg_write, mem_read, mem_write, branch, acc_write, imm_sel;
  logic [CNTW-1:0] retired;

  op_decode_seq #(.IW(IW), .OPW(OPW), .FW(FW), .LD_WAIT(LDW), .CNTW(CNTW)) dut (
    .CLK(CLK), .Reset(Reset), .inst_valid(inst_valid), .inst(inst), .inst_ready(inst_ready),
    .flush(flush), .out_ready(out_ready), .out_valid(out_valid), .out_op(out_op),
    .out_field(out_field), .out_mode(out_mode), .reg_write(reg_write), .mem_read(mem_read),
    .mem_write(mem_write), .branch(branch), .acc_write(acc_write), .imm_sel(imm_sel),
    .trap(trap), .retired(retired)
  );

  always #5 CLK = ~CLK;

  int compared = 0;
  int mismatched = 0;

  bit            mHave;
  int            mDelay;
  logic [IW-1:0] mInst;
  int            mRetired;
  bit            mTrapped;
  bit            checkEn = 1'b1;

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    compared++;
    if (actual !== expected) begin
      mismatched++;
      $display("[TB] FAIL %s: got %0h, expected %0h at %0t", tag, actual, expected, $time);
    end
  endtask

  // Control word {reg_write, mem_read, mem_write, branch, acc_write, imm_sel} from the ISA table.
  function automatic logic [5:0] refCtrl(input logic [IW-1:0] w);
    int op = int'(w[IW-1 -: OPW]);
    bit m  = w[FW-1];
    case (op)
      0, 2, 5, 6, 7, 9: return 6'b100000;
      10:               return 6'b100001;
      1:                return m ? 6'b001000 : 6'b110000;
      3:                return 6'b000100;
      4:                return m ? 6'b000010 : 6'b100000;
      8:                return 6'b000011;
      default:          return 6'b000000;
    endcase
  endfunction

  function automatic bit refIsLoad(input logic [IW-1:0] w);
    return (int'(w[IW-1 -: OPW]) == 1) && !w[FW-1];
  endfunction

  function automatic bit refIllegal(input logic [IW-1:0] w);
    return int'(w[IW-1 -: OPW]) >= 11;
  endfunction

  task automatic doReset();
    Reset = 1'b1; inst_valid = 1'b0; flush = 1'b0; out_ready = 1'b0;
    @(negedge CLK);
    checkOutput("ready_during_reset", inst_ready, 0);
    @(posedge CLK); #1;
    mHave = 0; mDelay = 0; mRetired = 0; mTrapped = 0; mInst = '0;
    checkOutput("reset_out_valid", out_valid, 0);
    checkOutput("reset_ctrl", {reg_write, mem_read, mem_write, branch, acc_write, imm_sel}, 0);
    checkOutput("reset_word", {out_op, out_field, out_mode}, 0);
    checkOutput("reset_trap", trap, 0);
    checkOutput("reset_retired", retired, 0);
    Reset = 1'b0;
  endtask

  // One clock cycle: drive, compare with the model mid-cycle, then advance the model at the edge.
  task automatic applyStimulus(input bit v, input logic [IW-1:0] w, input bit f, input bit r);
    bit expValid, expReady;
    inst_valid = v; inst = w; flush = f; out_ready = r;
    @(negedge CLK);
    expValid = mHave && (mDelay == 0);
    expReady = !mTrapped && !f && (!mHave || (expValid && r));
    if (checkEn) begin
      checkOutput("inst_ready", inst_ready, expReady);
      checkOutput("out_valid", out_valid, expValid);
      checkOutput("retired", retired, mRetired);
      checkOutput("trap", trap, mTrapped);
      if (expValid) begin
        checkOutput("out_op", out_op, mInst[IW-1 -: OPW]);
        checkOutput("out_field", out_field, mInst[FW-1:0]);
        checkOutput("out_mode", out_mode, mInst[FW-1]);
        checkOutput("ctrl", {reg_write, mem_read, mem_write, branch, acc_write, imm_sel}, refCtrl(mInst));
      end
    end
    @(posedge CLK);
    if (expValid && r) mRetired = (mRetired + 1) % (1 << CNTW);
    if (mTrapped) begin
    end else if (f) begin
      mHave = 0; mDelay = 0;
    end else if (v && expReady) begin
`ifdef ILLEGAL_OP_TRAP_EN
      if (refIllegal(w)) begin
        mTrapped = 1; mHave = 0;
      end else begin
        mHave = 1; mInst = w; mDelay = refIsLoad(w) ? LDW : 0;
      end
`else
      mHave = 1; mInst = w; mDelay = refIsLoad(w) ? LDW : 0;
`endif
    end else if (mHave && mDelay > 0) begin
      mDelay--;
    end else if (expValid && r) begin
      mHave = 0;
    end
    #1;
  endtask

  function automatic logic [IW-1:0] randInst();
    logic [OPW-1:0] op;
    logic [FW-1:0]  fld;
`ifdef ILLEGAL_OP_TRAP_EN
    op = OPW'($urandom_range(0, 10));
`else
    op = OPW'($urandom_range(0, 15));
`endif
    fld = FW'($urandom);
    return {op, fld};
  endfunction

  initial begin
    doReset();

    // ADD with immediate 3, then let it retire
    applyStimulus(1, 9'b0000_00011, 0, 1);
    applyStimulus(0, '0, 0, 1);
    checkOutput("add_retired", retired, 1);

    // LDS mode0: two wait cycles before presentation
    applyStimulus(1, 9'b0001_01010, 0, 1);
    applyStimulus(1, 9'b0000_00001, 0, 1);
    applyStimulus(1, 9'b0000_00001, 0, 1);
    applyStimulus(0, '0, 0, 1);
    applyStimulus(0, '0, 0, 1);

    // XOR held under backpressure, then LDS mode1 and BRC stream through
    applyStimulus(1, 9'b0010_00101, 0, 1);
    for (int i = 0; i < 3; i++) applyStimulus(1, 9'b0001_10110, 0, 0);
    applyStimulus(1, 9'b0001_10110, 0, 1);
    applyStimulus(1, 9'b0011_00111, 0, 1);
    applyStimulus(0, '0, 0, 1);
    applyStimulus(0, '0, 0, 1);

    // flush while waiting on a load, and while full under backpressure
    applyStimulus(1, 9'b0001_00001, 0, 1);
    applyStimulus(1, 9'b0000_00010, 1, 1);
    applyStimulus(0, '0, 0, 1);
    applyStimulus(1, 9'b0100_10001, 0, 1);
    applyStimulus(1, 9'b0000_00010, 1, 0);
    applyStimulus(0, '0, 0, 1);

    // random traffic with periodic mid-stream resets
    for (int i = 0; i < 3000; i++) begin
      if (i % 700 == 699) doReset();
      applyStimulus(bit'($urandom_range(0, 3) != 0), randInst(),
                    bit'($urandom_range(0, 9) == 0), bit'($urandom_range(0, 3) != 0));
    end

    // retired counter wrap
    doReset();
    checkEn = 1'b0;
    for (int i = 0; i < 65536; i++) applyStimulus(1, 9'b0000_00001, 0, 1);
    checkEn = 1'b1;
    checkOutput("retired_preload", retired, 65535);
    applyStimulus(0, '0, 0, 1);
    checkOutput("retired_wrap", retired, 0);
    applyStimulus(0, '0, 0, 1);

    // illegal opcode 1100
    doReset();
    applyStimulus(1, 9'b1100_00000, 0, 1);
`ifdef ILLEGAL_OP_TRAP_EN
    checkOutput("trap_set", trap, 1);
    applyStimulus(1, 9'b0000_00001, 1, 1);
    applyStimulus(1, 9'b0000_00001, 0, 1);
    checkOutput("trap_sticky", trap, 1);
    checkOutput("trap_no_retire", retired, 0);
`else
    applyStimulus(0, '0, 0, 1);
    checkOutput("nop_retired", retired, 1);
    checkOutput("nop_no_trap", trap, 0);
`endif
    doReset();
    applyStimulus(1, 9'b1010_10101, 0, 1);
    applyStimulus(0, '0, 0, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/op_decode_seq.md
# op_decode_seq

Registered, parametrised instruction-decode stage for the accumulator ISA (ADD, LDS, XOR, BRC, GST, LSB, MSB, LRS, ACC, ENQ, EQI). It sits between instruction fetch and the ALU/data-memory stage. It accepts one instruction per valid/ready handshake and holds the decoded control word until downstream accepts it. It also provides configurable load-wait sequencing, flush on taken branch, and a retired-instruction counter.

## Interface
- IW, 9, instruction width in bits; opcode is inst[IW-1 -: OPW]
- OPW, 4, opcode width; must be ≥4
- FW, IW-OPW, operand field width; field MSB is the mode bit
- LD_WAIT, 1, extra stall cycles for a load (0–3)
- CNTW, 16, retired-counter width

Ports:
- CLK  in  1  clock; all state updates on rising edge
- Reset  in  1  synchronous, active-high reset
- inst_valid  in  1  fetch presents an instruction
- inst  in  IW  instruction word
- inst_ready  out  1  stage can accept this cycle
- flush  in  1  taken branch; kill held/waiting instruction
- out_ready  in  1  downstream accepts the decoded word
- out_valid  out  1  decoded word valid
- out_op  out  OPW  registered opcode
- out_field  out  FW  registered operand field
- out_mode  out  1  registered mode bit (inst[FW-1])
- reg_write, mem_read, mem_write, branch, acc_write, imm_sel  out  1 each  control word
- trap  out  1  illegal opcode seen (sticky; macro-dependent)
- retired  out  CNTW  count of out handshakes

## Operation
- Decode (registered on accept):
  - reg_write: ADD, XOR, LSB, MSB, LRS, ENQ, EQI, LDS mode0, GST mode0
  - mem_read: LDS mode0; mem_write: LDS mode1
  - branch: BRC
  - acc_write: ACC, GST mode1
  - imm_sel: EQI, ACC
  - Opcodes 11..(2^OPW−1) drive all-zero controls (NOP).
- States:
  - EMPTY: out_valid=0, inst_ready=1. Accept → WAIT if load and LD_WAIT>0, else FULL.
  - WAIT: out_valid=0, inst_ready=0. Counter loads LD_WAIT on entry and decrements each cycle; at 1 → FULL.
  - FULL: out_valid=1, inst_ready=out_ready.
    - out_ready & inst_valid → re-accept (FULL or WAIT per new op).
    - out_ready & !inst_valid → EMPTY.
    - !out_ready → hold; all outputs stable.
  - TRAP (macro only): out_valid=0, inst_ready=0, trap=1 until Reset.
- flush has priority over every other event:
  - Next state EMPTY, inst_ready=0 that cycle, incoming word dropped.
  - Flush with out_valid&out_ready in the same cycle still counts as retired (downstream already took it).
- retired increments on out_valid&out_ready and wraps from 2^CNTW−1 to 0.

## Timing
- Reset: state EMPTY. out_valid=0, all controls=0, out_op/out_field/out_mode=0, trap=0, retired=0, wait counter=0. inst_ready=0 during the Reset cycle, 1 the cycle after.
- Latency from accept to out_valid:
  - Non-load: 1 cycle.
  - Load: 1+LD_WAIT cycles.
- Full throughput of 1 instr/cycle for non-loads while out_ready=1.
- inst_ready combinationally depends on out_ready and flush only; never on inst_valid.
- Reset mid-WAIT or mid-FULL abandons the instruction; it is not counted.

## Configuration
- ILLEGAL_OP_TRAP_EN defined:
  - Accepting opcode ≥11 → TRAP next cycle. trap=1, no further accepts, instruction not presented or retired.
  - Only Reset exits TRAP; flush does not.
- Undefined: opcode ≥11 decodes as NOP, passes through FULL normally, and counts as retired. trap is tied 0 and the TRAP state does not exist.

## Test plan
- Reset, then ADD (0000_00011) with out_ready=1 → out_valid next cycle, reg_write=1, out_field=5'b00011, retired=1 after handshake.
- LDS mode0 with LD_WAIT=2 → out_valid=0 for 2 cycles after accept, then out_valid=1 with mem_read=1 and reg_write=1; inst_ready=0 throughout WAIT.
- Back-to-back XOR, LDS mode1, BRC with out_ready held 0 for 3 cycles after the first → first word held stable, inst_ready=0; on release, words retire in order with mem_write=1 then branch=1.
- flush asserted in WAIT and in FULL with out_ready=0 → out_valid=0 next cycle, retired unchanged, incoming word in the flush cycle not accepted.
- retired preloaded via 65 535 handshakes, one more → retired=0.
- Opcode 1100 with macro defined → trap=1 next cycle, inst_ready=0 until Reset. Without the macro → NOP retired, trap=0.
